// File: rtl/simon_core.sv
// simon_core: memory-game sequencer. It shows a growing random button sequence and then checks the player's replay.
// Defining SIMON_HISCORE_EN adds a high-score register and drives the hs flag; otherwise hs is tied to 0.
module simon_core #(
    parameter int  NUM_BUTTONS   = 4,
    parameter int  DEPTH         = 16,
    parameter int  ON_TICKS      = 2,
    parameter int  TIMEOUT_TICKS = 8,
    localparam int BW = (NUM_BUTTONS > 2) ? $clog2(NUM_BUTTONS) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] in_code,
    input  logic          in_valid,
    input  logic [BW-1:0] rand_num,
    input  logic          tick,
    input  logic          start,
    output logic [BW-1:0] out_code,
    output logic          out_ena,
    output logic          win,
    output logic          lose,
    output logic          hs,
    output logic [LW-1:0] level
);
    localparam int            AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int            CMAX     = (ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS;
    localparam int            TW       = $clog2(CMAX + 1);
    localparam logic [BW:0]   NB_W     = (BW + 1)'(NUM_BUTTONS);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          mem_we;
    logic [BW-1:0] rand_red;
    logic [BW-1:0] cur_item;
    logic          code_ok;
    logic [BW-1:0] mem_q [DEPTH];

    // rand_num spans fewer than 2*NUM_BUTTONS values, so one subtraction folds it into range
    always_comb begin
        rand_red = rand_num;
        if ({1'b0, rand_num} >= NB_W) rand_red = rand_num - NB_W[BW-1:0];
    end

    assign cur_item = mem_q[idx_q[AW-1:0]];
    assign code_ok  = ({1'b0, in_code} < NB_W) && (in_code == cur_item);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    level_d = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                mem_we  = 1'b1;
                level_d = level_q + LW'(1);
                idx_d   = '0;
                cnt_d   = '0;
                state_d = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    cnt_d = '0;
                    if (idx_q < level_q) begin
                        state_d = S_SHOW_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_SHOW_ON: begin
                if (tick) begin
                    if (cnt_q == ON_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + LW'(1);
                        state_d = S_SHOW_OFF;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
            end
            S_WAIT_IN: begin
                // a press in the same cycle as a tick wins; that tick is not counted
                if (in_valid) begin
                    if (!code_ok) begin
                        state_d = S_LOSE;
                    end else if (idx_q == level_q - LW'(1)) begin
                        state_d = (level_q == DEPTH_L) ? S_WIN : S_GEN;
                    end else begin
                        idx_d = idx_q + LW'(1);
                        cnt_d = '0;
                    end
                end else if (tick) begin
                    if (cnt_q == TMO_LAST) state_d = S_LOSE;
                    else cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // sequence storage is abandoned rather than cleared on reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[level_q[AW-1:0]] <= rand_red;
    end

    assign out_ena  = (state_q == S_SHOW_ON);
    assign out_code = out_ena ? cur_item : '0;
    assign win      = (state_q == S_WIN);
    assign lose     = (state_q == S_LOSE);
    assign level    = level_q;

`ifdef SIMON_HISCORE_EN
    logic [LW-1:0] hi_q, hi_d, score;
    logic          hs_q, hs_d;
    logic          start_acc, result_entry;

    assign start_acc    = start && (state_q inside {S_IDLE, S_WIN, S_LOSE});
    assign result_entry = (state_q == S_WAIT_IN) && (state_d inside {S_WIN, S_LOSE});

    always_comb begin
        hi_d  = hi_q;
        hs_d  = hs_q;
        score = (state_d == S_WIN) ? DEPTH_L : level_q - LW'(1);
        if (start_acc) hs_d = 1'b0;
        if (result_entry && (score > hi_q)) begin
            hi_d = score;
            hs_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            hs_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            hs_q <= hs_d;
        end
    end

    assign hs = hs_q;
`else
    assign hs = 1'b0;
`endif

endmodule

// File: tb/tb_simon_core.sv
// Randomized self-checking bench for simon_core against a tick-schedule model of the game.
module tb_simon_core;
    localparam int NB    = 3;
    localparam int DEPTH = 4;
    localparam int ON    = 2;
    localparam int TMO   = 8;
    localparam int BW    = 2;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] in_code = '0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] rand_num = '0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] out_code;
    logic          out_ena, win, lose, hs;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simon_core #(.NUM_BUTTONS(NB), .DEPTH(DEPTH), .ON_TICKS(ON), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .rand_num(rand_num), .tick(tick), .start(start), .out_code(out_code),
        .out_ena(out_ena), .win(win), .lose(lose), .hs(hs), .level(level)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase of play, stored sequence, ticks seen since the round's display began,
    // player's position and idle-tick count while waiting for input.
    typedef enum int {P_IDLE, P_GEN, P_DISP, P_WAIT, P_WIN, P_LOSE} phase_t;
    phase_t ph = P_IDLE;
    int     seq[$];
    int     k = 0, idx = 0, tcnt = 0, hi = 0;
    bit     hs_m = 1'b0;

    task automatic finish_game(input bit won);
        int score;
        ph    = won ? P_WIN : P_LOSE;
        score = won ? DEPTH : seq.size() - 1;
`ifdef SIMON_HISCORE_EN
        if (score > hi) begin
            hi   = score;
            hs_m = 1'b1;
        end
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = P_IDLE; seq.delete(); k = 0; idx = 0; tcnt = 0; hi = 0; hs_m = 1'b0;
        end else begin
            case (ph)
                P_IDLE, P_WIN, P_LOSE:
                    if (start) begin seq.delete(); hs_m = 1'b0; ph = P_GEN; end
                P_GEN: begin
                    seq.push_back(int'(rand_num) >= NB ? int'(rand_num) - NB : int'(rand_num));
                    k  = 0;
                    ph = P_DISP;
                end
                P_DISP:
                    if (tick) begin
                        k++;
                        if (k == seq.size() * (ON + 1) + 1) begin ph = P_WAIT; idx = 0; tcnt = 0; end
                    end
                P_WAIT:
                    if (in_valid) begin
                        if (int'(in_code) < NB && int'(in_code) == seq[idx]) begin
                            if (idx == seq.size() - 1) begin
                                if (seq.size() == DEPTH) finish_game(1'b1);
                                else ph = P_GEN;
                            end else begin
                                idx++; tcnt = 0;
                            end
                        end else finish_game(1'b0);
                    end else if (tick) begin
                        tcnt++;
                        if (tcnt == TMO) finish_game(1'b0);
                    end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Item i is lit during display ticks [1+i*(ON+1), 1+i*(ON+1)+ON).
    initial forever begin
        int e_ena, e_code;
        @(negedge clk);
        e_ena  = (ph == P_DISP && k >= 1 && ((k - 1) % (ON + 1)) < ON) ? 1 : 0;
        e_code = e_ena ? seq[(k - 1) / (ON + 1)] : 0;
        chk("ena", out_ena, e_ena);
        chk("code", out_code, e_code);
        chk("win", win, ph == P_WIN);
        chk("lose", lose, ph == P_LOSE);
        chk("hs", hs, hs_m);
        chk("level", level, seq.size());
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_pulse(input int n = 1);
        repeat (n) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    endtask

    task automatic press(input int v);
        in_valid = 1'b1; in_code = BW'(v); step(); in_valid = 1'b0;
    endtask

    task automatic begin_game(input int r);
        rand_num = BW'(r); start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic play_game(input int v0, input int v1, input int v2, input int v3);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        start = 1'b1; step(); start = 1'b0;
        for (int lv = 1; lv <= DEPTH; lv++) begin
            rand_num = BW'(vals[lv-1]);
            step();
            tick_pulse(lv * (ON + 1) + 1);
            for (int j = 0; j < lv; j++) press(vals[j]);
        end
    endtask

    initial begin
        bit lazy = 1'b0;
        step(2);
        chk("rst_level", level, 0);
        chk("rst_ena", out_ena, 0);
        chk("rst_winlose", {win, lose, hs}, 0);
        rst_n = 1'b1;

        // first round shows code 2 after a one-tick gap, for two ticks
        begin_game(2);
        chk("r1_level", level, 1);
        chk("r1_gap", out_ena, 0);
        tick = 1'b1; step(); tick = 1'b0;
        chk("r1_on_ena", out_ena, 1);
        chk("r1_on_code", out_code, 2);
        step(3);
        tick = 1'b1; step(); tick = 1'b0;
        chk("r1_still_on", out_ena, 1);
        tick = 1'b1; step(); tick = 1'b0;
        chk("r1_off", out_ena, 0);
        tick = 1'b1; step(); tick = 1'b0;
        chk("r1_model_wait", int'(ph), int'(P_WAIT));

        // wrong press loses, level held
        press(1);
        chk("wrong_lose", lose, 1);
        chk("wrong_win", win, 0);
        chk("wrong_level", level, 1);

        // rand 3 folds to 0, then timeout after 8 idle ticks
        begin_game(3);
        tick = 1'b1; step(); tick = 1'b0;
        chk("fold_ena", out_ena, 1);
        chk("fold_code", out_code, 0);
        tick_pulse(3);
        tick_pulse(7);
        chk("tmo7_lose", lose, 0);
        tick_pulse(1);
        chk("tmo8_lose", lose, 1);

        // press on the 8th tick is accepted
        begin_game(1);
        tick_pulse(4);
        tick_pulse(7);
        tick = 1'b1; in_valid = 1'b1; in_code = 2'd1; step();
        tick = 1'b0; in_valid = 1'b0;
        chk("coinc_lose", lose, 0);
        step();
        chk("coinc_level", level, 2);

        // full game to DEPTH, twice
        rst_n = 1'b0; step(); rst_n = 1'b1;
        play_game(2, 0, 1, 2);
        chk("g1_win", win, 1);
        chk("g1_level", level, DEPTH);
`ifdef SIMON_HISCORE_EN
        chk("g1_hs", hs, 1);
`else
        chk("g1_hs", hs, 0);
`endif
        play_game(2, 0, 1, 2);
        chk("g2_win", win, 1);
        chk("g2_hs", hs, 0);

        // asynchronous reset while displaying
        begin_game(1);
        tick = 1'b1; step(); tick = 1'b0;
        chk("ar_pre_ena", out_ena, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ena", out_ena, 0);
        chk("ar_code", out_code, 0);
        chk("ar_level", level, 0);
        step(); rst_n = 1'b1;
        begin_game(2);
        chk("ar_restart_level", level, 1);

        for (int c = 0; c < 6000; c++) begin
            if (c % 300 == 0) lazy = ($urandom_range(0, 2) == 0);
            tick     = ($urandom_range(0, 2) == 0);
            rand_num = BW'($urandom_range(0, 3));
            start    = ($urandom_range(0, 5) == 0);
            in_valid = 1'b0;
            in_code  = BW'($urandom_range(0, 3));
            if (ph == P_WAIT) begin
                if ($urandom_range(0, 99) < (lazy ? 3 : 30)) begin
                    in_valid = 1'b1;
                    if ($urandom_range(0, 19) != 0) in_code = BW'(seq[idx]);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                in_valid = 1'b1;
            end
            rst_n = (c != 3000);
            step();
        end
        tick = 1'b0; start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
